// File: rtl/innerproduct_mac_sched.sv
// -----------------------------------------------------------------------------
// innerproduct_mac_sched
//
// Purpose:
//   Computes hprime = theta[0] + sum(mask[i] ? x[i]*theta[i] : 0), i=1..NFEAT-1,
//   with a single shared multiply-accumulate unit stepped one feature per cycle.
//   Features come from an external store with a 1-cycle-latency read port.
//   The theta coefficients and the per-feature enable mask can be loaded at
//   runtime while the scheduler is idle. All arithmetic wraps modulo 2^DW.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   theta_we/waddr/wdata       coefficient write port (IDLE only)
//   mask_we/mask_wdata         feature-enable mask write port (IDLE only)
//   cfg_err                    1-cycle pulse when a config write is rejected
//   start, busy                request an inner product / computation in flight
//   feat_rd, feat_addr         feature read strobe and index
//   feat_data                  feature value, valid the cycle after feat_rd
//   hprime, hprime_valid       result and its valid flag
//   hprime_ready               downstream accepts the result
// -----------------------------------------------------------------------------
module innerproduct_mac_sched #(
   parameter int NFEAT = 41,
   parameter int DW    = 32,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             theta_we,
   input  logic [AW-1:0]    theta_waddr,
   input  logic [DW-1:0]    theta_wdata,
   input  logic             mask_we,
   input  logic [NFEAT-1:0] mask_wdata,
   output logic             cfg_err,
   input  logic             start,
   output logic             busy,
   output logic             feat_rd,
   output logic [AW-1:0]    feat_addr,
   input  logic [DW-1:0]    feat_data,
   output logic [DW-1:0]    hprime,
   output logic             hprime_valid,
   input  logic             hprime_ready
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

   // Feature 1 is disabled out of reset; bit 0 is the bias slot and is ignored.
   localparam logic [NFEAT-1:0] MASK_RST = {{(NFEAT-2){1'b1}}, 2'b01};
   localparam logic [AW:0]      NFEAT_W  = (AW+1)'(NFEAT);
   localparam logic [AW-1:0]    LAST_IDX = AW'(NFEAT-1);

   state_t            state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [DW-1:0]     acc_q, acc_d;
   logic [DW-1:0]     hprime_q, hprime_d;
   logic              pend_valid_q, pend_valid_d;
   logic [AW-1:0]     pend_idx_q, pend_idx_d;
   logic              cfg_err_q, cfg_err_d;
   logic [DW-1:0]     theta_q [NFEAT];
   logic [DW-1:0]     theta_d [NFEAT];
   logic [NFEAT-1:0]  mask_q, mask_d;

   logic              cfg_write;
   logic              write_ok;
   logic              addr_bad;
   logic [DW-1:0]     prod;

   // Next-state logic: config writes, FSM sequencing and the MAC pipeline.
   // A read issued in RUN is remembered in pend_* so the product is formed one
   // cycle later when the feature store returns the data.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      acc_d        = acc_q;
      hprime_d     = hprime_q;
      pend_valid_d = 1'b0;
      pend_idx_d   = pend_idx_q;
      theta_d      = theta_q;
      mask_d       = mask_q;

      cfg_write = theta_we | mask_we;
      write_ok  = cfg_write && (state_q == IDLE) && !start;
      addr_bad  = ({1'b0, theta_waddr} >= NFEAT_W);
      cfg_err_d = (cfg_write && !write_ok) || (write_ok && theta_we && addr_bad);

      if (write_ok && theta_we && !addr_bad) begin
         theta_d[theta_waddr] = theta_wdata;
      end
      if (write_ok && mask_we) begin
         mask_d = mask_wdata;
      end

      // Product truncated to DW bits; sum wraps.
      prod = feat_data * theta_q[pend_idx_q];
      if (pend_valid_q) begin
         acc_d = acc_q + prod;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = theta_q[0];
               idx_d   = AW'(1);
               state_d = RUN;
            end
         end
         RUN: begin
            pend_valid_d = mask_q[idx_q];
            pend_idx_d   = idx_q;
            idx_d        = idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // acc_d already includes the final feature's contribution.
            hprime_d = acc_d;
            state_d  = HOLD;
         end
         HOLD: begin
            if (hprime_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         acc_q        <= '0;
         hprime_q     <= '0;
         pend_valid_q <= 1'b0;
         pend_idx_q   <= '0;
         cfg_err_q    <= 1'b0;
         mask_q       <= MASK_RST;
         for (int i = 0; i < NFEAT; i++) begin
            theta_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
         hprime_q     <= hprime_d;
         pend_valid_q <= pend_valid_d;
         pend_idx_q   <= pend_idx_d;
         cfg_err_q    <= cfg_err_d;
         mask_q       <= mask_d;
         for (int i = 0; i < NFEAT; i++) begin
            theta_q[i] <= theta_d[i];
         end
      end
   end

   assign busy         = (state_q != IDLE);
   assign hprime_valid = (state_q == HOLD);
   assign feat_rd      = (state_q == RUN) && mask_q[idx_q];
   assign feat_addr    = (state_q == RUN) ? idx_q : '0;
   assign hprime       = hprime_q;
   assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_innerproduct_mac_sched.sv
// -----------------------------------------------------------------------------
// tb_innerproduct_mac_sched
//
// Self-checking bench for innerproduct_mac_sched. A behavioural model keeps
// its own copy of theta/mask and computes the expected inner product with
// plain arithmetic; a small feature-store model answers reads one cycle late
// and drives random noise when no read was issued.
// -----------------------------------------------------------------------------
module tb_innerproduct_mac_sched;

   localparam int NFEAT = 41;
   localparam int DW    = 32;
   localparam int AW    = 6;
   localparam logic [NFEAT-1:0] MASK_DEFAULT = {{(NFEAT-2){1'b1}}, 2'b01};

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             theta_we = 1'b0;
   logic [AW-1:0]    theta_waddr = '0;
   logic [DW-1:0]    theta_wdata = '0;
   logic             mask_we = 1'b0;
   logic [NFEAT-1:0] mask_wdata = '0;
   logic             cfg_err;
   logic             start = 1'b0;
   logic             busy;
   logic             feat_rd;
   logic [AW-1:0]    feat_addr;
   logic [DW-1:0]    feat_data = '0;
   logic [DW-1:0]    hprime;
   logic             hprime_valid;
   logic             hprime_ready = 1'b0;

   logic [DW-1:0]    fmem    [0:63];
   logic [DW-1:0]    m_theta [0:NFEAT-1];
   logic [NFEAT-1:0] m_mask;

   int checks   = 0;
   int errors   = 0;
   int rd_count = 0;
   int bad_rd   = 0;

   innerproduct_mac_sched #(.NFEAT(NFEAT), .DW(DW), .AW(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .theta_we     (theta_we),
      .theta_waddr  (theta_waddr),
      .theta_wdata  (theta_wdata),
      .mask_we      (mask_we),
      .mask_wdata   (mask_wdata),
      .cfg_err      (cfg_err),
      .start        (start),
      .busy         (busy),
      .feat_rd      (feat_rd),
      .feat_addr    (feat_addr),
      .feat_data    (feat_data),
      .hprime       (hprime),
      .hprime_valid (hprime_valid),
      .hprime_ready (hprime_ready)
   );

   always #5 clk = ~clk;

   // Feature store: registered read port, random data when not read.
   always @(posedge clk) begin
      if (feat_rd) feat_data <= fmem[feat_addr];
      else         feat_data <= $urandom();
   end

   // Count feature reads and flag any read of a disabled or bias index.
   always @(posedge clk) begin
      if (rst_n && feat_rd) begin
         rd_count++;
         if (int'(feat_addr) == 0 || int'(feat_addr) >= NFEAT || !m_mask[feat_addr])
            bad_rd++;
      end
   end

   task checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] refModel();
      logic [DW-1:0] s;
      s = m_theta[0];
      for (int i = 1; i < NFEAT; i++)
         if (m_mask[i]) s = s + fmem[i] * m_theta[i];
      return s;
   endfunction

   task modelReset();
      for (int i = 0; i < NFEAT; i++) m_theta[i] = '0;
      m_mask = MASK_DEFAULT;
   endtask

   // One config write cycle while the DUT is idle.
   task writeCfg(input logic we_t, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                 input logic we_m, input logic [NFEAT-1:0] mdata);
      logic bad;
      theta_we = we_t; theta_waddr = addr; theta_wdata = data;
      mask_we = we_m;  mask_wdata = mdata;
      @(posedge clk); #1;
      theta_we = 1'b0; mask_we = 1'b0;
      bad = we_t && (int'(addr) >= NFEAT);
      checkOutput("cfg_err_wr", cfg_err, bad);
      if (we_t && !bad) m_theta[addr] = data;
      if (we_m) m_mask = mdata;
      if (bad) begin
         @(posedge clk); #1;
         checkOutput("cfg_err_pulse", cfg_err, 1'b0);
      end
   endtask

   task loadThetas(input logic [DW-1:0] t0, input logic [DW-1:0] ti);
      writeCfg(1'b1, '0, t0, 1'b0, '0);
      for (int i = 1; i < NFEAT; i++) writeCfg(1'b1, AW'(i), ti, 1'b0, '0);
   endtask

   // Runs one inner product: start, wait for valid, optional backpressure,
   // handshake, and the checks along the way.
   task applyStimulus(input int hold, input bit midwrite, input bit wr_with_start,
                      output logic [DW-1:0] result);
      logic [DW-1:0] exp;
      int lat;
      exp = refModel();
      rd_count = 0;
      bad_rd = 0;
      start = 1'b1;
      if (wr_with_start) begin
         theta_we = 1'b1; theta_waddr = '0; theta_wdata = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      start = 1'b0; theta_we = 1'b0;
      checkOutput("busy_after_start", busy, 1'b1);
      if (wr_with_start) checkOutput("cfg_err_start_wr", cfg_err, 1'b1);
      lat = 1;
      while (!hprime_valid && lat < 100) begin
         if (midwrite && lat == 10) begin
            theta_we = 1'b1; theta_waddr = AW'(4); theta_wdata = $urandom();
            mask_we = 1'b1;  mask_wdata = '0;
         end
         @(posedge clk); #1;
         lat++;
         if (midwrite && lat == 11) begin
            theta_we = 1'b0; mask_we = 1'b0;
            checkOutput("cfg_err_busy_wr", cfg_err, 1'b1);
         end
      end
      checkOutput("latency", lat, 42);
      checkOutput("hprime", hprime, exp);
      checkOutput("rd_count", rd_count, $countones(m_mask[NFEAT-1:1]));
      checkOutput("bad_rd", bad_rd, 0);
      for (int k = 0; k < hold; k++) begin
         start = (k % 2 == 1);
         hprime_ready = 1'b0;
         @(posedge clk); #1;
         checkOutput("hold_valid", hprime_valid, 1'b1);
         checkOutput("hold_data", hprime, exp);
         checkOutput("hold_busy", busy, 1'b1);
      end
      hprime_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      hprime_ready = 1'b0;
      start = 1'b0;
      checkOutput("hs_busy", busy, 1'b0);
      checkOutput("hs_valid", hprime_valid, 1'b0);
      checkOutput("hs_data_kept", hprime, exp);
      @(posedge clk); #1;
      checkOutput("start_in_hs_ignored", busy, 1'b0);
      result = hprime;
   endtask

   // Global watchdog so the bench always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DW-1:0] res;
      logic [63:0]   r;
      logic [NFEAT-1:0] mr;

      for (int i = 0; i < 64; i++) fmem[i] = '0;
      modelReset();

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_valid", hprime_valid, 1'b0);
      checkOutput("rst_feat_rd", feat_rd, 1'b0);
      checkOutput("rst_feat_addr", feat_addr, '0);
      checkOutput("rst_hprime", hprime, '0);
      checkOutput("rst_cfg_err", cfg_err, 1'b0);

      // Default mask, theta=1, x[i]=i
      for (int i = 0; i < 64; i++) fmem[i] = i;
      loadThetas(32'd1, 32'd1);
      applyStimulus(0, 1'b0, 1'b0, res);
      checkOutput("sc1_820", res, 32'd820);

      // Config protection: write while busy, bad address, write with start
      applyStimulus(0, 1'b1, 1'b0, res);
      checkOutput("sc5_midrun", res, 32'd820);
      writeCfg(1'b1, AW'(45), 32'h1234_5678, 1'b0, '0);
      applyStimulus(0, 1'b0, 1'b1, res);
      checkOutput("sc5_badaddr", res, 32'd820);

      // All-ones mask, theta0=5, others 2, x=3 (theta/mask written together once)
      writeCfg(1'b1, '0, 32'd5, 1'b1, '1);
      for (int i = 1; i < NFEAT; i++) writeCfg(1'b1, AW'(i), 32'd2, 1'b0, '0);
      for (int i = 0; i < 64; i++) fmem[i] = 32'd3;
      applyStimulus(0, 1'b0, 1'b0, res);
      checkOutput("sc2_245", res, 32'd245);

      // Overflow wrap
      loadThetas(32'd7, 32'd0);
      writeCfg(1'b1, AW'(2), 32'h0001_0000, 1'b0, '0);
      fmem[2] = 32'h0001_0000;
      applyStimulus(0, 1'b0, 1'b0, res);
      checkOutput("sc3_wrap7", res, 32'd7);
      writeCfg(1'b1, AW'(3), 32'hFFFF_FFFF, 1'b0, '0);
      fmem[3] = 32'd2;
      applyStimulus(0, 1'b0, 1'b0, res);
      checkOutput("sc3_wrap5", res, 32'd5);

      // Backpressure, then a fresh run
      applyStimulus(10, 1'b0, 1'b0, res);
      checkOutput("sc4_bp", res, 32'd5);
      applyStimulus(0, 1'b0, 1'b0, res);
      checkOutput("sc4_fresh", res, 32'd5);

      // Randomized models and features
      for (int it = 0; it < 4; it++) begin
         r  = {$urandom(), $urandom()};
         mr = r[NFEAT-1:0];
         if (it % 2 == 0) mr[0] = 1'b0;
         writeCfg(1'b0, '0, '0, 1'b1, mr);
         for (int i = 0; i < NFEAT; i++) writeCfg(1'b1, AW'(i), $urandom(), 1'b0, '0);
         for (int i = 0; i < 64; i++) fmem[i] = $urandom();
         applyStimulus($urandom_range(0, 4), 1'b0, 1'b0, res);
      end

      // Reset mid-run
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      modelReset();
      checkOutput("sc6_busy", busy, 1'b0);
      checkOutput("sc6_feat_rd", feat_rd, 1'b0);
      checkOutput("sc6_valid", hprime_valid, 1'b0);
      checkOutput("sc6_hprime", hprime, '0);
      checkOutput("sc6_cfg_err", cfg_err, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, res);
      checkOutput("sc6_zero", res, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
